// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: 3rd-order CIC decimator (delay 1) turning a PDM bitstream
// into signed PCM words, with a valid/ready output and a sticky overrun flag.
module pdm_cic_decimator #(
   parameter int DECIM_LOG2 = 6,
   parameter int PCM_WIDTH  = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 pdm_in,
   input  logic                 pdm_valid,
   output logic [PCM_WIDTH-1:0] pcm_data,
   output logic                 pcm_valid,
   input  logic                 pcm_ready,
   output logic                 overrun,
   input  logic                 overrun_clr
);
   localparam int W = 3*DECIM_LOG2+2;
   localparam int S = 3*DECIM_LOG2+1-PCM_WIDTH;

   logic [DECIM_LOG2-1:0] count;
   logic [W-1:0]          x;
   logic [W-1:0]          i1, i2, i3;
   logic [W-1:0]          i1_n, i2_n, i3_n;
   logic [W-1:0]          c1, c2, c3;
   logic [W-1:0]          d1, d2, d3;
   logic [W-1:0]          shifted;
   logic [PCM_WIDTH-1:0]  result;
   logic [1:0]            warm;
   logic                  v0, v1, v2;
   logic                  terminal, load, accept, in_range;

   assign x    = pdm_in ? W'(1) : '1;
   assign i1_n = i1 + x;
   assign i2_n = i2 + i1_n;
   assign i3_n = i3 + i2_n;

   assign terminal = pdm_valid && (&count);

   assign c3      = c2 - d3;
   assign shifted = $signed(c3) >>> S;

   // in range when every bit above the PCM sign bit matches it
   assign in_range = (&shifted[W-1:PCM_WIDTH-1]) | ~(|shifted[W-1:PCM_WIDTH-1]);
   assign result   = in_range ? shifted[PCM_WIDTH-1:0]
                   : {shifted[W-1], {(PCM_WIDTH-1){~shifted[W-1]}}};

   assign load   = v2 && (warm == 2'd3);
   assign accept = pcm_valid && pcm_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         count <= '0;
         i1    <= '0;
         i2    <= '0;
         i3    <= '0;
      end else if (pdm_valid) begin
         count <= count + 1'b1;
         i1    <= i1_n;
         i2    <= i2_n;
         i3    <= i3_n;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         v0   <= 1'b0;
         v1   <= 1'b0;
         v2   <= 1'b0;
         c1   <= '0;
         c2   <= '0;
         d1   <= '0;
         d2   <= '0;
         d3   <= '0;
         warm <= '0;
      end else begin
         v0 <= terminal;
         v1 <= v0;
         v2 <= v1;
         if (v0) begin
            c1 <= i3 - d1;
            d1 <= i3;
         end
         if (v1) begin
            c2 <= c1 - d2;
            d2 <= c1;
         end
         if (v2) begin
            d3 <= c2;
            if (warm != 2'd3)
               warm <= warm + 2'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pcm_data  <= '0;
         pcm_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (load) begin
            pcm_data  <= result;
            pcm_valid <= 1'b1;
         end else if (accept) begin
            pcm_valid <= 1'b0;
         end
         if (load && pcm_valid && !pcm_ready)
            overrun <= 1'b1;
         else if (overrun_clr)
            overrun <= 1'b0;
      end
   end
endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb_pdm_cic_decimator: directed PDM patterns with a scoreboard queue of
// expected PCM words and output cycles, drained by a separate monitor.
module tb_pdm_cic_decimator;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        pdm_in = 1'b0;
   logic        pdm_valid = 1'b0;
   logic        pcm_ready = 1'b0;
   logic        overrun_clr = 1'b0;
   logic [15:0] pcm_data;
   logic        pcm_valid;
   logic        overrun;

   always #5 clock = ~clock;

   pdm_cic_decimator #(.DECIM_LOG2(6), .PCM_WIDTH(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .pdm_in      (pdm_in),
      .pdm_valid   (pdm_valid),
      .pcm_data    (pcm_data),
      .pcm_valid   (pcm_valid),
      .pcm_ready   (pcm_ready),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   typedef struct {
      logic [15:0] d;
      int          t;
   } exp_t;

   exp_t        sb[$];
   int          cyc = 0;
   int          checks = 0;
   int          passes = 0;
   int          n_strobe = 0;
   bit          auto_push = 1'b0;
   logic [15:0] exp_val = '0;

   localparam logic [3:0] ONES = 4'b1111;
   localparam logic [3:0] ZERO = 4'b0000;
   localparam logic [3:0] ALT  = 4'b0101;
   localparam logic [3:0] P1110 = 4'b0111;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act === req)
         passes++;
      else
         $display("FAIL %s: got %0h, required %0h", name, act, req);
   endtask

   task automatic push(input logic [15:0] d, input int t);
      exp_t e;
      e.d = d;
      e.t = t;
      sb.push_back(e);
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (!reset && pcm_valid && pcm_ready) begin
         if (sb.size() == 0) begin
            check("unexpected_pcm_valid", {31'b0, pcm_valid}, 32'd0);
         end else begin
            e = sb.pop_front();
            check("pcm_data", {16'b0, pcm_data}, {16'b0, e.d});
            if (e.t >= 0)
               check("latency_cycle", cyc, e.t);
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic strobe(input logic b, input int gap);
      pdm_valid = 1'b1;
      pdm_in    = b;
      if (auto_push && (n_strobe % 64 == 63) && (n_strobe / 64 >= 3))
         push(exp_val, cyc + 4);
      n_strobe++;
      tick();
      pdm_valid = 1'b0;
      repeat (gap - 1) tick();
   endtask

   task automatic run(input logic [3:0] pat, input int n, input int gap);
      for (int i = 0; i < n; i++)
         strobe(pat[n_strobe % 4], gap);
   endtask

   task automatic do_reset(input string tag);
      reset     = 1'b1;
      pdm_valid = 1'b1;
      pdm_in    = 1'b1;
      repeat (2) tick();
      pdm_valid = 1'b0;
      reset     = 1'b0;
      n_strobe  = 0;
      check({tag, "_rst_data"}, {16'b0, pcm_data}, 32'd0);
      check({tag, "_rst_valid"}, {31'b0, pcm_valid}, 32'd0);
      check({tag, "_rst_overrun"}, {31'b0, overrun}, 32'd0);
   endtask

   task automatic drain(input string tag);
      repeat (3) tick();
      check({tag, "_sb_empty"}, sb.size(), 32'd0);
   endtask

   task automatic stream(input string tag, input logic [3:0] pat,
                         input logic [15:0] val, input int gap);
      do_reset(tag);
      pcm_ready = 1'b1;
      auto_push = 1'b1;
      exp_val   = val;
      run(pat, 8*64, gap);
      drain(tag);
      check({tag, "_overrun"}, {31'b0, overrun}, 32'd0);
   endtask

   initial begin
      stream("ones", ONES, 16'h7FFF, 16);
      stream("zeros", ZERO, 16'h8000, 4);
      stream("alt", ALT, 16'h0000, 4);
      stream("p1110", P1110, 16'h4000, 4);

      // backpressure
      do_reset("bp");
      pcm_ready = 1'b0;
      auto_push = 1'b0;
      run(ONES, 256, 4);
      check("bp_first_valid", {31'b0, pcm_valid}, 32'd1);
      check("bp_first_data", {16'b0, pcm_data}, 32'h7FFF);
      check("bp_first_overrun", {31'b0, overrun}, 32'd0);
      run(ALT, 192, 4);
      check("bp_over_data", {16'b0, pcm_data}, 32'h0000);
      check("bp_over_valid", {31'b0, pcm_valid}, 32'd1);
      check("bp_over_set", {31'b0, overrun}, 32'd1);
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      check("bp_over_clr", {31'b0, overrun}, 32'd0);
      push(16'h0000, -1);
      pcm_ready = 1'b1;
      tick();
      pcm_ready = 1'b0;
      check("bp_valid_fall", {31'b0, pcm_valid}, 32'd0);
      check("bp_sb_empty", sb.size(), 32'd0);
      run(ALT, 64, 4);
      check("bp_reload_valid", {31'b0, pcm_valid}, 32'd1);
      run(ALT, 63, 4);
      pdm_valid = 1'b1;
      pdm_in    = ALT[3];
      n_strobe++;
      tick();
      pdm_valid = 1'b0;
      repeat (2) tick();
      push(16'h0000, -1);
      pcm_ready = 1'b1;
      tick();
      pcm_ready = 1'b0;
      check("bp_sim_overrun", {31'b0, overrun}, 32'd0);
      check("bp_sim_valid", {31'b0, pcm_valid}, 32'd1);
      push(16'h0000, -1);
      pcm_ready = 1'b1;
      tick();
      pcm_ready = 1'b0;
      drain("bp");

      // reset mid-frame and mid-pipeline
      do_reset("mid");
      pcm_ready = 1'b1;
      auto_push = 1'b0;
      run(ONES, 30, 4);
      do_reset("mid2");
      run(ONES, 255, 4);
      strobe(1'b1, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      repeat (6) tick();
      check("mid_valid", {31'b0, pcm_valid}, 32'd0);
      check("mid_data", {16'b0, pcm_data}, 32'd0);
      check("mid_overrun", {31'b0, overrun}, 32'd0);
      n_strobe  = 0;
      auto_push = 1'b1;
      exp_val   = 16'h7FFF;
      run(ONES, 8*64, 4);
      drain("mid");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
